// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
// Shared AHB-Lite encodings (HTRANS, HBURST, HSIZE, HRESP) and the slave
// state type used by ahb_slave_mr and its address decoder.
// ---------------------------------------------------------------------------
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;

    localparam logic [2:0] HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] HSIZE_HALF    = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HSIZE_DWORD   = 3'b011;

    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;

    localparam logic [4:0] BEAT_MAX      = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

endpackage

// File: rtl/ahb_addr_decode.sv
// ---------------------------------------------------------------------------
// ahb_addr_decode
// Combinational address-phase checks: region match (lowest index wins),
// alignment to 2^size, transfer size against bus width, byte strobes.
// Ports:
//   addr_i   : address-phase HADDR
//   size_i   : address-phase HSIZE
//   valid_o  : address hits a region, is aligned and size fits the bus
//   region_o : index of the lowest matching region (0 when none)
//   strb_o   : byte-lane strobes for the transfer
// ---------------------------------------------------------------------------
module ahb_addr_decode #(
    parameter int                       DATA_WIDTH  = 32,
    parameter int                       NUM_REGIONS = 2,
    parameter logic [NUM_REGIONS*32-1:0] REGION_BASE = {32'h0000_0400, 32'h0000_0000},
    parameter logic [NUM_REGIONS*32-1:0] REGION_SIZE = {32'd1024, 32'd1024}
) (
    input  logic [31:0]             addr_i,
    input  logic [2:0]              size_i,
    output logic                    valid_o,
    output logic [1:0]              region_o,
    output logic [DATA_WIDTH/8-1:0] strb_o
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LANE_W = $clog2(STRB_W);

    logic [NUM_REGIONS-1:0] hit;
    logic                   any_hit;
    logic [7:0]             nbytes;
    logic [7:0]             lane;
    logic                   aligned;
    logic                   size_ok;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGIONS; gi++) begin : g_region
            logic [31:0] base;
            logic [31:0] span;
            assign base = REGION_BASE[32*gi +: 32];
            assign span = REGION_SIZE[32*gi +: 32];
            // Offset compare avoids overflow of base+size at the top of memory.
            assign hit[gi] = (addr_i >= base) && ((addr_i - base) < span);
        end
    endgenerate

    always_comb begin
        region_o = 2'd0;
        any_hit  = 1'b0;
        // Walk downwards so the lowest matching index is the last to write.
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                region_o = 2'(i);
                any_hit  = 1'b1;
            end
        end
    end

    assign nbytes  = 8'd1 << size_i;
    assign aligned = ((addr_i[7:0] & (nbytes - 8'd1)) == 8'd0);
    assign size_ok = (size_i <= 3'(LANE_W));
    assign lane    = 8'(addr_i[LANE_W-1:0]);
    assign valid_o = any_hit & aligned & size_ok;

    generate
        for (gi = 0; gi < STRB_W; gi++) begin : g_strb
            assign strb_o[gi] = (8'(gi) >= lane) && (8'(gi) < (lane + nbytes));
        end
    endgenerate

endmodule

// File: rtl/ahb_slave_mr.sv
// ---------------------------------------------------------------------------
// ahb_slave_mr
// AHB-Lite slave with NUM_REGIONS decoded address windows that forwards each
// data-phase beat to a simple backend (be_*), with wait and abort support
// and the two-cycle AHB ERROR response.
// Ports:
//   HCLK/HRESET           : clock, asynchronous active-high reset
//   HSEL..HWDATA          : AHB-Lite slave inputs
//   HRDATA/HREADYOUT/HRESP: AHB-Lite slave outputs
//   be_req..be_region     : backend beat request (valid in DATA state)
//   be_wait/be_err/be_rdata: backend stall, abort, read data
//   beat_count            : beat index within the current burst
// ---------------------------------------------------------------------------
module ahb_slave_mr
    import ahb_pkg::*;
#(
    parameter int                        DATA_WIDTH  = 32,
    parameter int                        NUM_REGIONS = 2,
    parameter logic [NUM_REGIONS*32-1:0] REGION_BASE = {32'h0000_0400, 32'h0000_0000},
    parameter logic [NUM_REGIONS*32-1:0] REGION_SIZE = {32'd1024, 32'd1024}
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic                    HSEL,
    input  logic                    HREADY,
    input  logic                    HWRITE,
    input  logic [31:0]             HADDR,
    input  logic [1:0]              HTRANS,
    input  logic [2:0]              HSIZE,
    input  logic [2:0]              HBURST,
    input  logic [DATA_WIDTH-1:0]   HWDATA,
    output logic [DATA_WIDTH-1:0]   HRDATA,
    output logic                    HREADYOUT,
    output logic                    HRESP,
    output logic                    be_req,
    output logic                    be_write,
    output logic [31:0]             be_addr,
    output logic [DATA_WIDTH/8-1:0] be_strb,
    output logic [DATA_WIDTH-1:0]   be_wdata,
    output logic [1:0]              be_region,
    input  logic                    be_wait,
    input  logic                    be_err,
    input  logic [DATA_WIDTH-1:0]   be_rdata,
    output logic [4:0]              beat_count
);

    localparam int STRB_W = DATA_WIDTH / 8;

    state_t              state_q, state_d;
    logic [31:0]         addr_q;
    logic                write_q;
    logic [STRB_W-1:0]   strb_q;
    logic [1:0]          region_q;
    logic [4:0]          beat_q;
    logic                burst_q;   // a NONSEQ has started the current burst

    logic                dec_valid;
    logic [1:0]          dec_region;
    logic [STRB_W-1:0]   dec_strb;
    logic                ready_out;
    logic                accept;
    logic                is_seq;
    logic                phase_ok;
    logic                unused_hburst;

    ahb_addr_decode #(
        .DATA_WIDTH  (DATA_WIDTH),
        .NUM_REGIONS (NUM_REGIONS),
        .REGION_BASE (REGION_BASE),
        .REGION_SIZE (REGION_SIZE)
    ) u_decode (
        .addr_i   (HADDR),
        .size_i   (HSIZE),
        .valid_o  (dec_valid),
        .region_o (dec_region),
        .strb_o   (dec_strb)
    );

    // Burst type does not change how beats are served.
    assign unused_hburst = ^HBURST;

    assign is_seq   = (HTRANS == HTRANS_SEQ);
    // An orphan SEQ (no NONSEQ since reset/error) is rejected like a bad address.
    assign phase_ok = dec_valid & ~(is_seq & ~burst_q);
    assign accept   = ready_out & HSEL & HREADY & HTRANS[1];

    always_comb begin
        ready_out = 1'b1;
        HRESP     = HRESP_OKAY;
        state_d   = state_q;
        case (state_q)
            ST_DATA: begin
                // An abort must not look like a completed beat to the master.
                ready_out = ~be_wait & ~be_err;
                if (be_err) begin
                    state_d = ST_ERR1;
                end else if (!be_wait) begin
                    state_d = accept ? (phase_ok ? ST_DATA : ST_ERR1) : ST_IDLE;
                end
            end
            ST_ERR1: begin
                ready_out = 1'b0;
                HRESP     = HRESP_ERROR;
                state_d   = ST_ERR2;
            end
            ST_ERR2: begin
                HRESP   = HRESP_ERROR;
                state_d = accept ? (phase_ok ? ST_DATA : ST_ERR1) : ST_IDLE;
            end
            default: begin
                state_d = accept ? (phase_ok ? ST_DATA : ST_ERR1) : ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            write_q  <= 1'b0;
            strb_q   <= '0;
            region_q <= '0;
            beat_q   <= '0;
            burst_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q   <= HADDR;
                write_q  <= HWRITE;
                strb_q   <= phase_ok ? dec_strb : '0;
                region_q <= dec_region;
                if (!is_seq) begin
                    beat_q <= 5'd1;
                end else if (beat_q != BEAT_MAX) begin
                    beat_q <= beat_q + 5'd1;
                end
            end
            if (state_d == ST_ERR1) begin
                burst_q <= 1'b0;
            end else if (accept && !is_seq) begin
                burst_q <= 1'b1;
            end
        end
    end

    assign HREADYOUT  = ready_out;
    assign be_req     = (state_q == ST_DATA);
    assign be_write   = write_q;
    assign be_addr    = addr_q;
    assign be_strb    = strb_q;
    assign be_region  = region_q;
    assign be_wdata   = HWDATA;
    assign HRDATA     = (state_q == ST_DATA) ? be_rdata : '0;
    assign beat_count = beat_q;

endmodule

// File: tb/tb_ahb_slave_mr.sv
module tb_ahb_slave_mr;
    import ahb_pkg::*;

    logic        HCLK, HRESET, HSEL, HREADY, HWRITE;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE, HBURST;
    logic [31:0] HWDATA, HRDATA;
    logic        HREADYOUT, HRESP;
    logic        be_req, be_write;
    logic [31:0] be_addr;
    logic [3:0]  be_strb;
    logic [31:0] be_wdata;
    logic [1:0]  be_region;
    logic        be_wait, be_err;
    logic [31:0] be_rdata;
    logic [4:0]  beat_count;

    int checks = 0;
    int errors = 0;

    ahb_slave_mr dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HREADY(HREADY),
        .HWRITE(HWRITE), .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE),
        .HBURST(HBURST), .HWDATA(HWDATA), .HRDATA(HRDATA),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .be_req(be_req),
        .be_write(be_write), .be_addr(be_addr), .be_strb(be_strb),
        .be_wdata(be_wdata), .be_region(be_region), .be_wait(be_wait),
        .be_err(be_err), .be_rdata(be_rdata), .beat_count(beat_count)
    );

    // Single-slave system: the bus ready is this slave's own ready.
    assign HREADY = HREADYOUT;

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cycle();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive_addr(input logic [1:0] trans, input logic [31:0] addr,
                              input logic [2:0] size, input logic wr, input logic [2:0] burst);
        HSEL   = 1'b1;
        HTRANS = trans;
        HADDR  = addr;
        HSIZE  = size;
        HWRITE = wr;
        HBURST = burst;
    endtask

    task automatic bus_idle();
        HTRANS = HTRANS_IDLE;
    endtask

    // Expect the two-cycle ERROR response starting at the current cycle (ERR1).
    task automatic expect_error(input string tag);
        check_val({tag, "_err1_ready"}, 64'(HREADYOUT), 64'd0);
        check_val({tag, "_err1_resp"},  64'(HRESP),     64'd1);
        check_val({tag, "_err1_req"},   64'(be_req),    64'd0);
        cycle(); #1;
        check_val({tag, "_err2_ready"}, 64'(HREADYOUT), 64'd1);
        check_val({tag, "_err2_resp"},  64'(HRESP),     64'd1);
        check_val({tag, "_err2_req"},   64'(be_req),    64'd0);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  size;
        logic        ok;
        logic [3:0]  strb;
        logic [1:0]  region;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{32'h0000_03FC, 3'd2, 1'b1, 4'hF, 2'd0};
        vecs[1] = '{32'h0000_0400, 3'd0, 1'b1, 4'h1, 2'd1};
        vecs[2] = '{32'h0000_07FF, 3'd0, 1'b1, 4'h8, 2'd1};
        vecs[3] = '{32'h0000_07FE, 3'd1, 1'b1, 4'hC, 2'd1};
        vecs[4] = '{32'h0000_0800, 3'd2, 1'b0, 4'h0, 2'd0};
        vecs[5] = '{32'h0000_0002, 3'd2, 1'b0, 4'h0, 2'd0};
        vecs[6] = '{32'h0000_0000, 3'd3, 1'b0, 4'h0, 2'd0};
        vecs[7] = '{32'h0000_0006, 3'd1, 1'b1, 4'hC, 2'd0};

        HRESET = 1'b1; HSEL = 1'b0; HWRITE = 1'b0; HADDR = '0;
        HTRANS = HTRANS_IDLE; HSIZE = '0; HBURST = '0; HWDATA = '0;
        be_wait = 1'b0; be_err = 1'b0; be_rdata = '0;

        // Reset state
        #3;
        check_val("rst_req",    64'(be_req),     64'd0);
        check_val("rst_ready",  64'(HREADYOUT),  64'd1);
        check_val("rst_resp",   64'(HRESP),      64'd0);
        check_val("rst_strb",   64'(be_strb),    64'd0);
        check_val("rst_region", 64'(be_region),  64'd0);
        check_val("rst_beat",   64'(beat_count), 64'd0);
        $display("txn reset");
        cycle(); cycle();
        HRESET = 1'b0;

        // Single word write, zero wait
        drive_addr(HTRANS_NONSEQ, 32'h0000_0010, HSIZE_WORD, 1'b1, HBURST_SINGLE);
        cycle();
        bus_idle(); HWDATA = 32'hDEAD_BEEF; #1;
        check_val("wr_req",    64'(be_req),    64'd1);
        check_val("wr_write",  64'(be_write),  64'd1);
        check_val("wr_addr",   64'(be_addr),   64'h10);
        check_val("wr_strb",   64'(be_strb),   64'hF);
        check_val("wr_region", 64'(be_region), 64'd0);
        check_val("wr_wdata",  64'(be_wdata),  64'hDEAD_BEEF);
        check_val("wr_ready",  64'(HREADYOUT), 64'd1);
        check_val("wr_resp",   64'(HRESP),     64'd0);
        check_val("wr_beat",   64'(beat_count), 64'd1);
        cycle(); #1;
        check_val("wr_done_req", 64'(be_req), 64'd0);
        $display("txn write 00000010");

        // Halfword read with two wait states
        drive_addr(HTRANS_NONSEQ, 32'h0000_0402, HSIZE_HALF, 1'b0, HBURST_SINGLE);
        cycle();
        bus_idle(); be_wait = 1'b1; #1;
        check_val("rd_w1_ready", 64'(HREADYOUT), 64'd0);
        check_val("rd_w1_req",   64'(be_req),    64'd1);
        check_val("rd_strb",     64'(be_strb),   64'hC);
        check_val("rd_region",   64'(be_region), 64'd1);
        check_val("rd_write",    64'(be_write),  64'd0);
        cycle(); #1;
        check_val("rd_w2_ready", 64'(HREADYOUT), 64'd0);
        check_val("rd_w2_addr",  64'(be_addr),   64'h402);
        cycle();
        be_wait = 1'b0; be_rdata = 32'h1234_0000; #1;
        check_val("rd_ready", 64'(HREADYOUT), 64'd1);
        check_val("rd_data",  64'(HRDATA),    64'h1234_0000);
        check_val("rd_resp",  64'(HRESP),     64'd0);
        cycle(); #1;
        check_val("rd_done_req", 64'(be_req), 64'd0);
        $display("txn read 00000402");

        // Unmapped address
        drive_addr(HTRANS_NONSEQ, 32'h0000_0900, HSIZE_WORD, 1'b0, HBURST_SINGLE);
        cycle(); bus_idle();
        expect_error("unmapped");
        cycle(); #1;
        check_val("unmapped_after_resp", 64'(HRESP), 64'd0);
        $display("txn unmapped 00000900");

        // Misaligned word
        drive_addr(HTRANS_NONSEQ, 32'h0000_0001, HSIZE_WORD, 1'b1, HBURST_SINGLE);
        cycle(); bus_idle();
        expect_error("misalign");
        cycle();
        $display("txn misaligned 00000001");

        // Backend abort while also stalling
        drive_addr(HTRANS_NONSEQ, 32'h0000_0020, HSIZE_WORD, 1'b1, HBURST_SINGLE);
        cycle();
        bus_idle(); be_err = 1'b1; be_wait = 1'b1; #1;
        check_val("abort_req",   64'(be_req),    64'd1);
        check_val("abort_ready", 64'(HREADYOUT), 64'd0);
        cycle();
        be_err = 1'b0; be_wait = 1'b0;
        expect_error("abort");
        cycle();
        $display("txn backend abort 00000020");

        // SEQ with no NONSEQ since the error
        drive_addr(HTRANS_SEQ, 32'h0000_0030, HSIZE_WORD, 1'b1, HBURST_INCR);
        cycle(); bus_idle();
        expect_error("orphan_seq");
        cycle();
        $display("txn orphan seq 00000030");

        // Decode boundary table
        for (int i = 0; i < 8; i++) begin
            drive_addr(HTRANS_NONSEQ, vecs[i].addr, vecs[i].size, 1'b1, HBURST_SINGLE);
            cycle(); bus_idle(); #1;
            if (vecs[i].ok) begin
                check_val($sformatf("vec%0d_req", i),    64'(be_req),    64'd1);
                check_val($sformatf("vec%0d_strb", i),   64'(be_strb),   64'(vecs[i].strb));
                check_val($sformatf("vec%0d_region", i), 64'(be_region), 64'(vecs[i].region));
                check_val($sformatf("vec%0d_resp", i),   64'(HRESP),     64'd0);
                cycle();
            end else begin
                expect_error($sformatf("vec%0d", i));
                cycle();
            end
            $display("txn vector %0d addr %08h size %0d", i, vecs[i].addr, vecs[i].size);
        end

        // INCR4 write with one BUSY between beats 2 and 3
        drive_addr(HTRANS_NONSEQ, 32'h0000_0020, HSIZE_WORD, 1'b1, HBURST_INCR4);
        cycle();
        drive_addr(HTRANS_SEQ, 32'h0000_0024, HSIZE_WORD, 1'b1, HBURST_INCR4); #1;
        check_val("b1_req",  64'(be_req),     64'd1);
        check_val("b1_addr", 64'(be_addr),    64'h20);
        check_val("b1_beat", 64'(beat_count), 64'd1);
        cycle();
        drive_addr(HTRANS_BUSY, 32'h0000_0028, HSIZE_WORD, 1'b1, HBURST_INCR4); #1;
        check_val("b2_req",  64'(be_req),     64'd1);
        check_val("b2_addr", 64'(be_addr),    64'h24);
        check_val("b2_beat", 64'(beat_count), 64'd2);
        cycle();
        drive_addr(HTRANS_SEQ, 32'h0000_0028, HSIZE_WORD, 1'b1, HBURST_INCR4); #1;
        check_val("busy_req",   64'(be_req),     64'd0);
        check_val("busy_ready", 64'(HREADYOUT),  64'd1);
        check_val("busy_resp",  64'(HRESP),      64'd0);
        check_val("busy_beat",  64'(beat_count), 64'd2);
        cycle();
        drive_addr(HTRANS_SEQ, 32'h0000_002C, HSIZE_WORD, 1'b1, HBURST_INCR4); #1;
        check_val("b3_req",  64'(be_req),     64'd1);
        check_val("b3_addr", 64'(be_addr),    64'h28);
        check_val("b3_beat", 64'(beat_count), 64'd3);
        cycle();
        bus_idle(); #1;
        check_val("b4_req",  64'(be_req),     64'd1);
        check_val("b4_addr", 64'(be_addr),    64'h2C);
        check_val("b4_beat", 64'(beat_count), 64'd4);
        cycle(); #1;
        check_val("burst_done_req",  64'(be_req),     64'd0);
        check_val("burst_done_beat", 64'(beat_count), 64'd4);
        $display("txn incr4 write 00000020 with busy");

        // Reset pulsed in the middle of a stalled read
        drive_addr(HTRANS_NONSEQ, 32'h0000_0404, HSIZE_WORD, 1'b0, HBURST_SINGLE);
        cycle();
        bus_idle(); be_wait = 1'b1; #1;
        check_val("mid_req",    64'(be_req),    64'd1);
        check_val("mid_region", 64'(be_region), 64'd1);
        HRESET = 1'b1; #1;
        check_val("mid_rst_req",    64'(be_req),     64'd0);
        check_val("mid_rst_ready",  64'(HREADYOUT),  64'd1);
        check_val("mid_rst_resp",   64'(HRESP),      64'd0);
        check_val("mid_rst_strb",   64'(be_strb),    64'd0);
        check_val("mid_rst_region", 64'(be_region),  64'd0);
        check_val("mid_rst_beat",   64'(beat_count), 64'd0);
        cycle();
        HRESET = 1'b0; be_wait = 1'b0;
        cycle(); #1;
        check_val("post_rst_req", 64'(be_req), 64'd0);
        drive_addr(HTRANS_NONSEQ, 32'h0000_0008, HSIZE_WORD, 1'b1, HBURST_SINGLE);
        cycle();
        bus_idle(); #1;
        check_val("post_rst_wr_req",  64'(be_req),     64'd1);
        check_val("post_rst_wr_addr", 64'(be_addr),    64'h8);
        check_val("post_rst_wr_strb", 64'(be_strb),    64'hF);
        check_val("post_rst_wr_beat", 64'(beat_count), 64'd1);
        cycle();
        $display("txn reset mid-data then write 00000008");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_slave_mr.md
AHB_SLAVE_MR -- requirements
Module: ahb_slave_mr

Interface
REQ-001 Param DATA_WIDTH, default 32; HWDATA/HRDATA/be_wdata/be_rdata width; legal 32 or 64.
REQ-002 Param NUM_REGIONS, default 2; number of decoded address regions; legal 1..4.
REQ-003 Param REGION_BASE, default {32'h0000_0400, 32'h0000_0000}; packed NUM_REGIONS*32 bits; region i base at bits [32i+31:32i].
REQ-004 Param REGION_SIZE, default {32'd1024, 32'd1024}; packed NUM_REGIONS*32 bits; byte size of region i, nonzero.
REQ-005 Clocking and reset: one clock; reset is asynchronous and active-high.
REQ-006 HCLK in 1: sole clock, rising edge.
REQ-007 HRESET in 1: asynchronous active-high reset.
REQ-008 HSEL, HREADY, HWRITE in 1 each: select, bus-ready, write flag.
REQ-009 HADDR in 32; HTRANS in 2; HSIZE in 3; HBURST in 3; HWDATA in DATA_WIDTH.
REQ-010 HRDATA out DATA_WIDTH; HREADYOUT out 1; HRESP out 1 (0 OKAY, 1 ERROR).
REQ-011 be_req out 1: data-phase beat active toward backend.
REQ-012 be_write out 1; be_addr out 32; be_strb out DATA_WIDTH/8; be_wdata out DATA_WIDTH; be_region out 2.
REQ-013 be_wait in 1: backend stall; be_err in 1: backend abort; be_rdata in DATA_WIDTH.
REQ-014 beat_count out 5: beat index of current burst.

Function
REQ-015 Address phase accepted when HSEL & HREADY & HTRANS[1] at a rising HCLK edge; HADDR/HWRITE/HSIZE/HTRANS registered that edge.
REQ-016 States IDLE, DATA, ERR1, ERR2; acceptance per REQ-015 evaluated in every state where HREADYOUT=1 (IDLE, DATA-completing, ERR2).
REQ-017 Accepted transfer valid iff HADDR in some region [base, base+size-1], HADDR aligned to 2^HSIZE, and 2^HSIZE <= DATA_WIDTH/8.
REQ-018 Region decode: lowest matching index wins; index registered to be_region.
REQ-019 Valid acceptance -> DATA; invalid acceptance -> ERR1; no acceptance -> IDLE.
REQ-020 HTRANS IDLE or BUSY with HSEL: no state change from IDLE, zero-wait OKAY, be_req stays 0.
REQ-021 DATA: be_req=1, be_write/be_addr/be_strb from registered phase, be_wdata=HWDATA, HRDATA=be_rdata, HREADYOUT=~be_wait, HRESP=0.
REQ-022 DATA with be_wait=1 holds state and all registered values; beat completes in first cycle with be_wait=0.
REQ-023 be_err=1 in DATA -> ERR1 next cycle regardless of be_wait; beat not completed toward master.
REQ-024 ERR1: HREADYOUT=0, HRESP=1; ERR2: HREADYOUT=1, HRESP=1; ERR1->ERR2 unconditionally.
REQ-025 be_req=0 in IDLE, ERR1, ERR2.
REQ-026 be_strb: bytes [a, a+2^HSIZE-1] set, a = HADDR mod (DATA_WIDTH/8); all others 0.
REQ-027 beat_count: set 1 on accepted NONSEQ, +1 on accepted SEQ, saturates at 31, else holds.
REQ-028 SEQ accepted with no prior NONSEQ since reset or error: treated as invalid (ERR1).
REQ-029 Read data latency: HRDATA valid in the cycle HREADYOUT=1 of DATA; zero added registers.

Reset
REQ-030 HRESET asserted: state IDLE, registered phase cleared, beat_count 0, be_req 0, HREADYOUT 1, HRESP 0, be_strb 0, be_region 0.
REQ-031 Reset mid-DATA or mid-error abandons transfer; no be_req in first cycle after deassertion.

Structure
REQ-032 Package ahb_pkg holds HTRANS/HBURST/HSIZE/HRESP constants and state enum type.
REQ-033 Sub-module ahb_addr_decode: combinational region match, alignment and size checks, strobe generation.

Verification
REQ-034 Write 32'h0000_0010 HSIZE=2, HWDATA=32'hDEAD_BEEF, be_wait=0 -> be_req 1 cycle, be_strb=4'hF, be_region=0, OKAY.
REQ-035 Read 32'h0000_0402 HSIZE=1, be_wait=1 for 2 cycles, be_rdata=32'h1234_0000 -> HREADYOUT low 2 cycles, be_strb=4'hC, be_region=1.
REQ-036 Access 32'h0000_0900 -> ERR1 (HREADYOUT 0, HRESP 1), ERR2 (HREADYOUT 1, HRESP 1), be_req never 1.
REQ-037 Misaligned 32'h0000_0001 HSIZE=2 -> two-cycle ERROR; be_err=1 in DATA -> same ERROR sequence.
REQ-038 INCR4 write from 32'h0000_0020 with one BUSY -> beat_count 1,2,3,4; four be_req beats; BUSY gives OKAY, no be_req.
REQ-039 HRESET pulsed mid-DATA with be_wait=1 -> all outputs at reset values immediately; next valid NONSEQ served normally.
